// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU issue path: function codes, instruction
// word layout and the constants used to build bubbles.
package alu_pipe_pkg;

    // ALU function codes; encodings above FUNC_LAST are illegal.
    typedef enum logic [3:0] {
        FUNC_ADD  = 4'd0,
        FUNC_SUB  = 4'd1,
        FUNC_MUL  = 4'd2,
        FUNC_SELA = 4'd3,
        FUNC_SELB = 4'd4,
        FUNC_AND  = 4'd5,
        FUNC_OR   = 4'd6,
        FUNC_XOR  = 4'd7,
        FUNC_NEGA = 4'd8,
        FUNC_NEGB = 4'd9,
        FUNC_SRA  = 4'd10,
        FUNC_SLA  = 4'd11
    } func_e;

    localparam int FUNC_LAST = 11;
    localparam int INSTR_W   = 24;

    // Bit positions of the fields inside a packed instruction word.
    localparam int FUNC_MSB = 23;
    localparam int FUNC_LSB = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 16;
    localparam int RS1_MSB  = 15;
    localparam int RS1_LSB  = 12;
    localparam int RS2_MSB  = 11;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    // A bubble selects operand A, which with rs1 = rd is a harmless copy.
    localparam logic [3:0] BUBBLE_FUNC = FUNC_SELA;

    // Field order matches the bit positions above (func in the MSBs).
    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] addr;
    } instr_t;

    function automatic logic is_illegal(input logic [3:0] f);
        return f > 4'(FUNC_LAST);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO for instruction words. Push while full and pop
// while empty are ignored, so callers may present requests unconditionally.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Instruction buffer and issue stage in front of the pipelined ALU.
//
// Handshake: a word transfers at a posedge where in_valid && in_ready;
// in_ready is !full and does not depend on in_valid or on a same-edge pop.
//
// The ALU samples its inputs every second clock. slot_q marks those edges;
// only there do the output registers reload and the FIFO pop. A bubble is
// loaded when the FIFO is empty, when the head is an illegal function (the
// head is then dropped and err_illegal pulses), or when the head reads the
// register written by the instruction currently on the outputs.
module alu_issue_unit
    import alu_pipe_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] NOP_REG  = 4'd0,
    parameter logic [7:0] NOP_ADDR = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [3:0]               rd,
    output logic [3:0]               func,
    output logic [7:0]               addr,
    output logic                     issue_valid,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    instr_t               bubble;
    instr_t               head;
    logic [INSTR_W-1:0]   head_raw;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 hazard;

    logic                 slot_q;
    instr_t               out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    assign bubble = '{func: BUBBLE_FUNC, rd: NOP_REG, rs1: NOP_REG,
                      rs2: 4'd0, addr: NOP_ADDR};

    assign push     = in_valid && !fifo_full;
    assign in_ready = !fifo_full;
    assign head     = instr_t'(head_raw);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_instr),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // RAW hazard: head reads the destination of the live instruction.
    assign hazard = valid_q && ((head.rs1 == out_q.rd) || (head.rs2 == out_q.rd));

    // Issue decision at slot edges, in priority order; outputs hold otherwise.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        pop     = 1'b0;
        if (slot_q) begin
            if (fifo_empty) begin
                out_d   = bubble;
                valid_d = 1'b0;
            end else if (is_illegal(head.func)) begin
                pop     = 1'b1;
                out_d   = bubble;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else if (hazard) begin
                out_d   = bubble;
                valid_d = 1'b0;
            end else begin
                pop     = 1'b1;
                out_d   = head;
                valid_d = 1'b1;
            end
        end
    end

    // Slot toggle and registered ALU-facing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q  <= 1'b1;
            out_q   <= bubble;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= !slot_q;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign func        = out_q.func;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign addr        = out_q.addr;
    assign issue_valid = valid_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed scenarios plus a random stream, all
// checked against a queue-based model of the issue rules.
module tb_alu_issue_unit;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        issue_valid;
    logic        err_illegal;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    alu_issue_unit #(.DEPTH(DEPTH), .NOP_REG(4'd0), .NOP_ADDR(8'hFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .issue_valid (issue_valid),
        .err_illegal (err_illegal),
        .fifo_count  (fifo_count)
    );

    // ---------------- reference model ----------------
    logic [23:0] exp_q[$];      // words accepted but not yet consumed
    logic [23:0] got_q[$];      // words seen issuing on the outputs
    logic        m_slot;
    logic        m_valid;
    logic        m_err;
    logic [23:0] m_out;         // {func, rd, rs1, rs2, addr}
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          issue_cyc[16];
    int          t_err;
    int          err_pulses;

    function automatic logic [23:0] mk(input int f, input int d, input int a,
                                       input int b, input int ad);
        logic [3:0] f4, d4, a4, b4;
        logic [7:0] ad8;
        f4 = 4'(f); d4 = 4'(d); a4 = 4'(a); b4 = 4'(b); ad8 = 8'(ad);
        return {f4, d4, a4, b4, ad8};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_out   = {4'd3, 4'd0, 4'd0, 4'd0, 8'hFF};
        m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".in_ready"},    32'(in_ready),    32'(exp_q.size() < DEPTH));
        chk({tag, ".fifo_count"},  32'(fifo_count),  32'(exp_q.size()));
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(m_valid));
        chk({tag, ".err_illegal"}, 32'(err_illegal), 32'(m_err));
        chk({tag, ".fields"},      32'({func, rd, rs1, rs2, addr}), 32'(m_out));
    endtask

    task automatic clear_log();
        got_q.delete();
        for (int i = 0; i < 16; i++) issue_cyc[i] = -100;
        t_err = -100;
        err_pulses = 0;
        cyc = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid = 1'b0;
        in_instr = '0;
        reset = 1'b0;
        #2;
        exp_q.delete();
        m_slot = 1'b1;
        m_err  = 1'b0;
        model_bubble();
        clear_log();
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    task automatic step(input logic v, input logic [23:0] w, output logic acc);
        logic [23:0] head;
        logic        issue_edge;
        in_valid = v;
        in_instr = w;
        acc = v && (exp_q.size() < DEPTH);
        @(posedge clk);
        cyc++;
        issue_edge = m_slot;
        m_err = 1'b0;
        if (m_slot) begin
            if (exp_q.size() == 0) begin
                model_bubble();
            end else begin
                head = exp_q[0];
                if (head[23:20] >= 4'd12) begin
                    void'(exp_q.pop_front());
                    model_bubble();
                    m_err = 1'b1;
                end else if (m_valid && (head[15:12] == m_out[19:16] ||
                                         head[11:8]  == m_out[19:16])) begin
                    model_bubble();
                end else begin
                    void'(exp_q.pop_front());
                    m_out   = head;
                    m_valid = 1'b1;
                end
            end
        end
        if (acc) exp_q.push_back(w);
        m_slot = !m_slot;
        #1;
        check_outputs("step");
        if (issue_edge && issue_valid === 1'b1) begin
            issue_cyc[func] = cyc;
            got_q.push_back({func, rd, rs1, rs2, addr});
        end
        if (err_illegal === 1'b1) begin
            err_pulses++;
            t_err = cyc;
        end
    endtask

    // Present a word until it is accepted (bounded).
    task automatic push_word(input logic [23:0] w);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, w, acc);
            tries++;
        end
        chk("push_accepted", 32'(acc), 32'(1));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, acc);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [23:0] w;
        logic [23:0] pushed[$];
        logic        acc;
        int          guard;

        in_valid = 1'b0;
        in_instr = '0;
        reset = 1'b1;
        #1;

        // Reset with idle input
        do_reset();
        idle(3);

        // Independent pair issues back to back
        do_reset();
        push_word(mk(0, 3, 1, 2, 8'h10));   // ADD r3 <- r1, r2
        push_word(mk(7, 6, 4, 5, 8'h20));   // XOR r6 <- r4, r5
        idle(6);
        chk("indep_gap", 32'(issue_cyc[7] - issue_cyc[0]), 32'(2));

        // RAW hazard: one bubble, 4 cycles apart
        do_reset();
        push_word(mk(0, 3, 1, 2, 8'h11));   // ADD r3
        push_word(mk(1, 4, 3, 5, 8'h12));   // SUB reads r3
        idle(8);
        chk("raw_gap", 32'(issue_cyc[1] - issue_cyc[0]), 32'(4));

        // Illegal opcode dropped, following AND issues next slot edge
        do_reset();
        push_word(mk(13, 1, 2, 3, 8'h33));
        push_word(mk(5, 4, 6, 7, 8'h44));
        idle(6);
        chk("illegal_pulses", 32'(err_pulses), 32'(1));
        chk("illegal_and_gap", 32'(issue_cyc[5] - t_err), 32'(2));

        // Backpressure across pointer wrap
        do_reset();
        pushed.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            w = mk(i % 12, 8 + i, i, i, 8'h50 + i);
            pushed.push_back(w);
            push_word(w);
        end
        chk("bp_full_count", 32'(fifo_count), 32'(DEPTH));
        chk("bp_full_ready", 32'(in_ready), 32'(0));
        idle(20);
        chk("bp_issued_n", 32'(got_q.size()), 32'(DEPTH + 2));
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < got_q.size()) chk("bp_order", 32'(got_q[i]), 32'(pushed[i]));
        end

        // Reset mid-burst with 3 words queued
        do_reset();
        guard = 0;
        while (exp_q.size() != 3 && guard < 20) begin
            step(1'b1, mk(guard % 12, 9, 10, 11, guard), acc);
            guard++;
        end
        chk("midburst_queued", 32'(fifo_count), 32'(3));
        do_reset();
        idle(2);

        // Random stream with frequent hazards and illegal words
        do_reset();
        for (int i = 0; i < 500; i++) begin
            w = mk($urandom_range(0, 15), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, w, acc);
        end
        idle(20);
        chk("random_drained", 32'(fifo_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
